wirecube_line_raster: RTL and testbench
=======================================

Name: wirecube_line_raster

Overview:
- Bresenham line rasteriser for the wireframe cube renderer.
- Sits directly downstream of the projection stage: accepts one projected edge (two screen-space endpoints) per command.
- Emits the pixels of that edge, one per accepted handshake, to the line-buffer / pixel writer that feeds the VGA output path of tt_um_tt08_wirecube.

Parameters:
- COORD_W, 11, coordinate width, signed two's complement. Covers -1024..1023, so off-screen endpoints are representable.
- H_RES, 640, visible width. Used only by the clip feature.
- V_RES, 480, visible height. Used only by the clip feature.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  endpoint pair presented.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_x0  in  COORD_W  start x, signed.
- cmd_y0  in  COORD_W  start y, signed.
- cmd_x1  in  COORD_W  end x, signed.
- cmd_y1  in  COORD_W  end y, signed.
- pix_valid  out  1  pix_x/pix_y hold a pixel.
- pix_ready  in  1  consumer accepts the pixel.
- pix_x  out  COORD_W  pixel x, signed.
- pix_y  out  COORD_W  pixel y, signed.
- busy  out  1  high from command accept until return to IDLE.
- line_done  out  1  one-cycle pulse when the final pixel has been consumed (or skipped).

Behaviour:
- Reset: state=IDLE; cmd_ready=1, pix_valid=0, busy=0, line_done=0, pix_x=0, pix_y=0. Reset takes effect immediately, including mid-line; the in-flight line is dropped with no line_done.
- States and transitions:
  - IDLE: cmd_ready=1. cmd_valid&cmd_ready registers the endpoints -> SETUP.
  - SETUP (1 cycle):
    - dx=|x1-x0|, dy=-|y1-y0|, sx=sign(x1-x0), sy=sign(y1-y0), err=dx+dy, cur=(x0,y0).
    - dx, dy and err are COORD_W+2 bits; e2=2*err is COORD_W+3 bits. No overflow is possible for any input pair.
    - -> DRAW.
  - DRAW:
    - pix_valid=1, pix_x/pix_y=cur.
    - Step fires on pix_valid&pix_ready. If cur==(x1,y1): -> DONE. Otherwise, using e2=2*err:
      - if e2>=dy: err+=dy, x+=sx.
      - if e2<=dx: err+=dx, y+=sy.
      - Both corrections use the same pre-update e2.
    - While pix_ready=0, pix_valid, pix_x and pix_y hold stable.
  - DONE (1 cycle): line_done=1, busy=0 next -> IDLE.
- Latency: command accept -> first pix_valid = 2 cycles. Full throughput thereafter is 1 pixel/cycle. After the final pixel handshake, cmd_ready returns 2 cycles later.
- Degenerate input: x0==x1 and y0==y1 emits exactly one pixel.
- Command/pixel overlap: cmd_ready is low outside IDLE. cmd_valid there is ignored and the command is not latched.
- busy is high in SETUP, DRAW and DONE.

Optional Feature:
- Macro: WIRECUBE_LINE_CLIP_EN.
- Defined: in DRAW, a pixel with x<0, x>=H_RES, y<0 or y>=V_RES is not presented. pix_valid=0, the stepper advances that cycle without waiting for pix_ready, and line_done still pulses.
- Undefined: every pixel is presented regardless of coordinate; the consumer handles bounds. H_RES and V_RES are unused.

Decomposition:
- Package wirecube_pkg:
  - COORD_W default.
  - H_RES / V_RES.
  - typedef coord_t (signed [COORD_W-1:0]).
  - typedef point_t struct {x, y}.
  - enum raster_state_t {IDLE, SETUP, DRAW, DONE}.
- No sub-module needed. The single-step Bresenham update may be split into a combinational wirecube_bres_step (cur, err, d, s -> next cur, next err) for unit testing.

Test Plan:
- Horizontal: (0,0)->(3,0), pix_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles. First pixel 2 cycles after accept. line_done pulses once.
- Steep: (0,0)->(1,3) -> exactly (0,0),(0,1),(1,2),(1,3). Reverse (1,3)->(0,0) -> (1,3),(1,2),(0,1),(0,0).
- Point: (5,7)->(5,7) -> single pixel (5,7), line_done, cmd_ready high 2 cycles after its handshake.
- Backpressure: diagonal (0,0)->(2,2) with pix_ready toggling 1,0,0,1,0,1 -> pix_x/pix_y stable while stalled. Sequence (0,0),(1,1),(2,2). A cmd_valid asserted mid-line is not accepted.
- Reset mid-line: (0,0)->(100,0), rst_n low after 10 pixels -> outputs at reset values immediately, no line_done. The next command starts cleanly.
- Clip (macro defined): (-2,0)->(2,0) -> only (0,0),(1,0),(2,0) presented, line_done pulses. Macro undefined: 5 pixels starting at (-2,0).

Source files
------------

// File: rtl/wirecube_pkg.sv
// wirecube_pkg: shared types and constants for the wireframe cube line path.
//
//   COORD_W      signed screen-coordinate width (covers -1024..1023)
//   H_RES/V_RES  visible raster size, used only when the optional clip
//                feature (macro WIRECUBE_LINE_CLIP_EN) is compiled in
//   coord_t      one signed screen coordinate
//   point_t      packed {x, y} screen point
//   raster_state_t  line rasteriser control states
package wirecube_pkg;

  localparam int COORD_W = 11;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } raster_state_t;

endpackage

// File: rtl/wirecube_bres_step.sv
// wirecube_bres_step: one combinational Bresenham step.
//
// Given the current point and error term, produces the next point and
// error term. Both axis decisions use the same pre-update e2 = 2*err.
//
// Ports:
//   cur_x, cur_y   current pixel (signed, COORD_W)
//   err            current error term (signed, COORD_W+2)
//   dx             |x1-x0|  (signed, COORD_W+2, >= 0)
//   dy             -|y1-y0| (signed, COORD_W+2, <= 0)
//   sx_neg, sy_neg 1 = step towards decreasing x / y
//   nxt_x, nxt_y   next pixel
//   nxt_err        next error term
module wirecube_bres_step #(
  parameter int COORD_W = 11
) (
  input  logic signed [COORD_W-1:0] cur_x,
  input  logic signed [COORD_W-1:0] cur_y,
  input  logic signed [COORD_W+1:0] err,
  input  logic signed [COORD_W+1:0] dx,
  input  logic signed [COORD_W+1:0] dy,
  input  logic                      sx_neg,
  input  logic                      sy_neg,
  output logic signed [COORD_W-1:0] nxt_x,
  output logic signed [COORD_W-1:0] nxt_y,
  output logic signed [COORD_W+1:0] nxt_err
);

  localparam int EW  = COORD_W + 2;
  localparam int E2W = COORD_W + 3;
  localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1);

  logic signed [E2W-1:0] e2;
  logic signed [E2W-1:0] dx_ext;
  logic signed [E2W-1:0] dy_ext;
  logic                  x_step;
  logic                  y_step;

  assign e2     = $signed({err, 1'b0});
  assign dx_ext = $signed({dx[EW-1], dx});
  assign dy_ext = $signed({dy[EW-1], dy});
  assign x_step = (e2 >= dy_ext);
  assign y_step = (e2 <= dx_ext);

  // NOTE: every output gets a default before the conditional updates so the
  // block stays purely combinational; a missing default would infer a latch.
  always_comb begin
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    nxt_err = err;
    if (x_step) begin
      nxt_err = nxt_err + dy;
      nxt_x   = sx_neg ? (cur_x - ONE) : (cur_x + ONE);
    end
    if (y_step) begin
      nxt_err = nxt_err + dx;
      nxt_y   = sy_neg ? (cur_y - ONE) : (cur_y + ONE);
    end
  end

endmodule

// File: rtl/wirecube_line_raster.sv
// wirecube_line_raster: Bresenham line rasteriser for the wireframe cube.
//
// Accepts one projected edge (x0,y0)->(x1,y1) per command and emits its
// pixels from (x0,y0) to (x1,y1) inclusive, one per pix_valid&pix_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_x0..cmd_y1        signed endpoints
//   pix_valid/pix_ready   pixel handshake
//   pix_x, pix_y          signed pixel coordinate (held while stalled)
//   busy                  high from command accept until back in IDLE
//   line_done             one-cycle pulse after the final pixel
//
// Optional feature, macro WIRECUBE_LINE_CLIP_EN: off-screen pixels are not
// presented; the stepper walks over them without waiting for pix_ready.
module wirecube_line_raster
  import wirecube_pkg::*;
#(
  parameter int COORD_W = wirecube_pkg::COORD_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [COORD_W-1:0] cmd_x0,
  input  logic signed [COORD_W-1:0] cmd_y0,
  input  logic signed [COORD_W-1:0] cmd_x1,
  input  logic signed [COORD_W-1:0] cmd_y1,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic signed [COORD_W-1:0] pix_x,
  output logic signed [COORD_W-1:0] pix_y,
  output logic                      busy,
  output logic                      line_done
);

  localparam int EW = COORD_W + 2;

  raster_state_t state, state_nxt;

  logic signed [COORD_W-1:0] cur_x, cur_y;
  logic signed [COORD_W-1:0] end_x, end_y;
  logic signed [EW-1:0]      dx, dy, err;
  logic                      sx_neg, sy_neg;

  // Setup-stage arithmetic, widened by two bits so |x1-x0| never overflows.
  logic signed [EW-1:0] diff_x, diff_y;
  logic signed [EW-1:0] abs_x, abs_y;

  assign diff_x = $signed({{2{end_x[COORD_W-1]}}, end_x})
                - $signed({{2{cur_x[COORD_W-1]}}, cur_x});
  assign diff_y = $signed({{2{end_y[COORD_W-1]}}, end_y})
                - $signed({{2{cur_y[COORD_W-1]}}, cur_y});
  assign abs_x  = diff_x[EW-1] ? -diff_x : diff_x;
  assign abs_y  = diff_y[EW-1] ? -diff_y : diff_y;

  logic signed [COORD_W-1:0] nxt_x, nxt_y;
  logic signed [EW-1:0]      nxt_err;

  wirecube_bres_step #(
    .COORD_W (COORD_W)
  ) u_step (
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .err     (err),
    .dx      (dx),
    .dy      (dy),
    .sx_neg  (sx_neg),
    .sy_neg  (sy_neg),
    .nxt_x   (nxt_x),
    .nxt_y   (nxt_y),
    .nxt_err (nxt_err)
  );

  logic at_end;
  logic on_screen;
  logic step;

  assign at_end = (cur_x == end_x) && (cur_y == end_y);

`ifdef WIRECUBE_LINE_CLIP_EN
  localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
  localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);
  assign on_screen = !cur_x[COORD_W-1] && (cur_x < X_LIM) &&
                     !cur_y[COORD_W-1] && (cur_y < Y_LIM);
`else
  assign on_screen = 1'b1;
`endif

  // Control: outputs are pure decodes of the state plus the pixel handshake.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    pix_valid = 1'b0;
    busy      = 1'b1;
    line_done = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: state_nxt = DRAW;
      DRAW: begin
        pix_valid = on_screen;
        // A hidden pixel is skipped without waiting for the consumer.
        step      = on_screen ? pix_ready : 1'b1;
        if (step && at_end) state_nxt = DONE;
      end
      DONE: begin
        line_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the state so pix_x and
  // pix_y read 0 straight out of reset; there is no storage array here that
  // would make resetting everything costly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur_x  <= '0;
      cur_y  <= '0;
      end_x  <= '0;
      end_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; the stepper relies on err/cur updating together.
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_x <= cmd_x0;
            cur_y <= cmd_y0;
            end_x <= cmd_x1;
            end_y <= cmd_y1;
          end
        end
        SETUP: begin
          dx     <= abs_x;
          dy     <= -abs_y;
          err    <= abs_x - abs_y;
          sx_neg <= diff_x[EW-1];
          sy_neg <= diff_y[EW-1];
        end
        DRAW: begin
          if (step && !at_end) begin
            cur_x <= nxt_x;
            cur_y <= nxt_y;
            err   <= nxt_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_x = cur_x;
  assign pix_y = cur_y;

endmodule

// File: tb/tb_wirecube_line_raster.sv
// tb_wirecube_line_raster: self-checking bench for wirecube_line_raster.
// The reference model walks each line with plain integer arithmetic and
// builds the queue of pixels the consumer must receive. Compile with
// +define+WIRECUBE_LINE_CLIP_EN to check the clipping build.
module tb_wirecube_line_raster;

  localparam int W = 11;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic signed [W-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic                pix_valid;
  logic                pix_ready;
  logic signed [W-1:0] pix_x, pix_y;
  logic                busy;
  logic                line_done;

  always #5 clk = ~clk;

  wirecube_line_raster #(
    .COORD_W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
    .line_done (line_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model output.
  int exp_x[$];
  int exp_y[$];
  int lead_skip;   // hidden pixels before the first presented one
  int trail_skip;  // hidden pixels after the last presented one
  int total_pix;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic build_model(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    bit vis, seen;
    exp_x.delete();
    exp_y.delete();
    lead_skip = 0; trail_skip = 0; total_pix = 0; seen = 0;
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0; y = y0;
    forever begin
      vis = 1'b1;
`ifdef WIRECUBE_LINE_CLIP_EN
      vis = (x >= 0) && (x < 640) && (y >= 0) && (y < 480);
`endif
      total_pix++;
      if (vis) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
        seen = 1'b1;
        trail_skip = 0;
      end else if (!seen) begin
        lead_skip++;
      end else begin
        trail_skip++;
      end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // rdy_mode: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1,0,1.
  // poke: drive a stray command while the line is in flight.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int rdy_mode, input bit poke, input string name);
    int got_x[$];
    int got_y[$];
    int cyc, first_valid, last_hs, done_cnt, done_cyc, vcyc;
    bit stalled;
    int px, py;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    build_model(x0, y0, x1, y1);
    @(negedge clk);
    cmd_x0 = x0[W-1:0]; cmd_y0 = y0[W-1:0];
    cmd_x1 = x1[W-1:0]; cmd_y1 = y1[W-1:0];
    cmd_valid = 1'b1;
    pix_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready_idle: got %b expected 1", name, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1; first_valid = -1; last_hs = -1; done_cnt = 0; done_cyc = -1;
    vcyc = 0; stalled = 0; px = 0; py = 0;
    while (cyc < 20000) begin
      if (stalled) begin
        checks++;
        if (pix_valid !== 1'b1 || int'(pix_x) != px || int'(pix_y) != py) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                   name, pix_valid, pix_x, pix_y, px, py);
        end
      end
      case (rdy_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = pat[vcyc % 6];
      endcase
      if (pix_valid === 1'b1) vcyc++;
      if (poke) begin
        cmd_valid = (cyc >= 3 && cyc <= 5);
        cmd_x0 = 50; cmd_y0 = 50; cmd_x1 = 60; cmd_y1 = 60;
        if (cyc >= 3 && cyc <= 5) begin
          checks++;
          if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_while_busy: got ready=%b busy=%b expected 0/1",
                     name, cmd_ready, busy);
          end
        end
      end
      if (pix_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (line_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (pix_valid === 1'b1 && pix_ready) begin
        got_x.push_back(int'(pix_x));
        got_y.push_back(int'(pix_y));
        last_hs = cyc;
      end
      stalled = (pix_valid === 1'b1) && !pix_ready;
      px = int'(pix_x); py = int'(pix_y);
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s return_idle: got ready=%b busy=%b expected 1/0",
                   name, cmd_ready, busy);
        end
        break;
      end
      @(negedge clk);
      cyc++;
    end
    pix_ready = 1'b0;
    cmd_valid = 1'b0;

    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s timeout: got no line_done expected one", name);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s line_done_count: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (got_x.size() != exp_x.size()) begin
      errors++;
      $display("FAIL %s pixel_count: got %0d expected %0d", name, got_x.size(), exp_x.size());
    end
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
      checks++;
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) begin
        errors++;
        $display("FAIL %s pixel[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                 name, i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      end
    end
    if (exp_x.size() > 0) begin
      // Hidden leading pixels each take one cycle before the first shows.
      checks++;
      if (first_valid != 2 + lead_skip) begin
        errors++;
        $display("FAIL %s first_latency: got %0d expected %0d", name, first_valid, 2 + lead_skip);
      end
      checks++;
      if (done_cyc != last_hs + 1 + trail_skip) begin
        errors++;
        $display("FAIL %s done_timing: got %0d expected %0d", name, done_cyc, last_hs + 1 + trail_skip);
      end
    end else begin
      checks++;
      if (done_cyc != 2 + total_pix) begin
        errors++;
        $display("FAIL %s done_timing_hidden: got %0d expected %0d", name, done_cyc, 2 + total_pix);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; pix_ready = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0 ||
        line_done !== 1'b0 || pix_x !== '0 || pix_y !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b busy=%b done=%b (%0d,%0d) expected 1 0 0 0 (0,0)",
               cmd_ready, pix_valid, busy, line_done, pix_x, pix_y);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_horizontal();
    run_line(0, 0, 3, 0, 0, 1'b0, "horizontal");
  endtask

  task automatic test_steep();
    run_line(0, 0, 1, 3, 0, 1'b0, "steep");
    run_line(1, 3, 0, 0, 0, 1'b0, "steep_rev");
  endtask

  task automatic test_point();
    run_line(5, 7, 5, 7, 0, 1'b0, "point");
  endtask

  task automatic test_backpressure();
    run_line(0, 0, 2, 2, 2, 1'b1, "backpressure");
    // The stray command must not have been latched.
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL stray_cmd_latched: got busy=%b v=%b expected 0/0", busy, pix_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_line(10, 20, 4, 17, 0, 1'b0, "b2b_a");
    run_line(-3, 5, 2, -4, 1, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    int hs, cyc;
    hs = 0; cyc = 0;
    @(negedge clk);
    cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 100; cmd_y1 = 0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    pix_ready = 1'b1;
    while (hs < 10 && cyc < 100) begin
      if (pix_valid === 1'b1) begin
        checks++;
        if (int'(pix_x) != hs || int'(pix_y) != 0) begin
          errors++;
          $display("FAIL reset_mid_pixel[%0d]: got (%0d,%0d) expected (%0d,0)", hs, pix_x, pix_y, hs);
        end
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (hs != 10) begin
      errors++;
      $display("FAIL reset_mid_timeout: got %0d pixels expected 10", hs);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0 ||
        line_done !== 1'b0 || pix_x !== '0 || pix_y !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: got rdy=%b v=%b busy=%b done=%b (%0d,%0d) expected 1 0 0 0 (0,0)",
               cmd_ready, pix_valid, busy, line_done, pix_x, pix_y);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (line_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_done: got %b expected 0", line_done);
      end
    end
    pix_ready = 1'b0;
    rst_n = 1'b1;
    run_line(3, 4, 6, 5, 0, 1'b0, "after_reset");
  endtask

  task automatic test_clip();
    // Clip build presents (0,0)..(2,0); plain build presents all five.
    run_line(-2, 0, 2, 0, 0, 1'b0, "clip_left");
    run_line(637, 478, 642, 482, 1, 1'b0, "clip_corner");
  endtask

  task automatic test_random();
    int x0, y0, x1, y1;
    for (int i = 0; i < 30; i++) begin
      x0 = int'($urandom_range(0, 90)) - 30;
      y0 = int'($urandom_range(0, 90)) - 30;
      x1 = int'($urandom_range(0, 90)) - 30;
      y1 = int'($urandom_range(0, 90)) - 30;
      run_line(x0, y0, x1, y1, 1, 1'b0, "random");
    end
    // Extreme coordinates exercise the widened error arithmetic.
    run_line(-1024, -1024, 1023, 1023, 0, 1'b0, "extreme_diag");
    run_line(1023, -1024, -1024, 1000, 0, 1'b0, "extreme_skew");
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_point();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_clip();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
